// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: bimodal branch predictor with an in-flight branch FIFO.
// Fetch gets a combinational prediction from a table of 2-bit saturating
// counters. Each predicted branch is queued until execute resolves it in order.
// A mispredict raises a one-cycle flush pulse with the corrected PC.
// The mispredict also squashes every younger in-flight branch.
// Resolves are then held off for FLUSH_CYCLES cycles while the pipeline refills.
// Optional feature: define BP_STATS_EN to enable the branch/mispredict
// statistics counters; without it both statistics outputs are tied to zero.
module branch_pred_ctrl #(
  parameter int BHT_BITS     = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_target,
  output logic        fetch_stall,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  output logic        incorrect_pred,
  output logic [31:0] redirect_pc,
  output logic        resolve_err,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispred_cnt
);

  localparam int BHT_ENTRIES = 1 << BHT_BITS;
  localparam int PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam int HOLD_W      = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLUSH_CYCLES);

  // One in-flight branch: what is needed to train the table and to redirect.
  typedef struct packed {
    logic [BHT_BITS-1:0] idx;
    logic                pred;
    logic [31:0]         fall;
    logic [31:0]         target;
  } entry_t;

  logic [1:0]          bht [BHT_ENTRIES];
  entry_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;
  logic [HOLD_W-1:0]   holdoff;

  logic [BHT_BITS-1:0] fetch_idx;
  logic [31:0]         fall_pc;
  entry_t              head_entry;
  logic                fifo_empty;
  logic                fifo_full;
  logic                pop;
  logic                push;
  logic                mispredict;
  logic [1:0]          trained_ctr;

  // Wrap-around pointer increment; works for any depth, not just powers of 2.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Prediction reads the registered table, so a same-cycle update from a
  // resolve to the same index is only seen by the next fetch.
  assign fetch_idx  = fetch_pc[BHT_BITS+1:2];
  assign pred_taken = bht[fetch_idx][1];
  assign fall_pc    = fetch_pc + 32'd4;
  assign pred_pc    = pred_taken ? fetch_target : fall_pc;

  assign head_entry = fifo_mem[head];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);

  // Resolves are only honoured outside the post-flush holdoff window.
  assign pop         = resolve_valid && !fifo_empty && (holdoff == '0);
  assign mispredict  = pop && (resolve_taken != head_entry.pred);
  assign fetch_stall = fifo_full && !pop;
  assign push        = fetch_valid && !fetch_stall && !mispredict;

  // Saturating update of the counter belonging to the resolving branch.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    trained_ctr = bht[head_entry.idx];
    if (resolve_taken) begin
      if (trained_ctr != 2'b11) trained_ctr = trained_ctr + 2'b01;
    end else begin
      if (trained_ctr != 2'b00) trained_ctr = trained_ctr - 2'b01;
    end
  end

  // FIFO pointers and occupancy; a mispredict empties the queue outright.
  always_ff @(posedge clk) begin
    // NOTE: clocked blocks use <= so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (mispredict) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; occupancy tracks validity, so stale contents are never consumed.
    if (push) begin
      fifo_mem[tail] <= '{idx: fetch_idx, pred: pred_taken, fall: fall_pc, target: fetch_target};
    end
  end

  // Branch history table: reset to weakly not-taken, trained on each pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (pop) begin
      bht[head_entry.idx] <= trained_ctr;
    end
  end

  // Post-mispredict holdoff counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      holdoff <= '0;
    end else if (mispredict) begin
      holdoff <= HOLD_LOAD;
    end else if (holdoff != '0) begin
      holdoff <= holdoff - HOLD_W'(1);
    end
  end

  // Registered flush pulse and redirect target, stable for a whole cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      incorrect_pred <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      incorrect_pred <= mispredict;
      if (mispredict) begin
        redirect_pc <= resolve_taken ? head_entry.target : head_entry.fall;
      end
    end
  end

  // Sticky error: execute resolved a branch that was never in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      resolve_err <= 1'b0;
    end else if (resolve_valid && fifo_empty && (holdoff == '0)) begin
      resolve_err <= 1'b1;
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] branch_q;
  logic [15:0] mispred_q;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      if (pop && (branch_q != 16'hFFFF))        branch_q  <= branch_q + 16'd1;
      if (mispredict && (mispred_q != 16'hFFFF)) mispred_q <= mispred_q + 16'd1;
    end
  end

  assign branch_cnt  = branch_q;
  assign mispred_cnt = mispred_q;
`else
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: directed scenarios plus randomized traffic for
// branch_pred_ctrl, checked against a queue-based behavioural model.
module tb_branch_pred_ctrl;

  localparam int DEPTH = 4;
  localparam int FLUSH = 4;
  localparam int NIDX  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_target = '0;
  logic        fetch_stall;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic        incorrect_pred;
  logic [31:0] redirect_pc;
  logic        resolve_err;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;

  branch_pred_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_target  (fetch_target),
    .fetch_stall   (fetch_stall),
    .pred_taken    (pred_taken),
    .pred_pc       (pred_pc),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .incorrect_pred(incorrect_pred),
    .redirect_pc   (redirect_pc),
    .resolve_err   (resolve_err),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of in-flight branches and integer counters.
  typedef struct {
    int          idx;
    bit          pred;
    logic [31:0] fall;
    logic [31:0] tgt;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_ctr[NIDX];
  int          m_hold;
  bit          m_err;
  bit          m_ip;
  logic [31:0] m_redir;
  int          m_br;
  int          m_mis;

  function automatic void model_reset();
    foreach (m_ctr[i]) m_ctr[i] = 1;
    mq.delete();
    m_hold  = 0;
    m_err   = 0;
    m_ip    = 0;
    m_redir = '0;
    m_br    = 0;
    m_mis   = 0;
  endfunction

  function automatic int stat_exp(input int v);
`ifdef BP_STATS_EN
    return (v > 65535) ? 65535 : v;
`else
    return 0 * v;
`endif
  endfunction

  // Registered outputs reflect the model state after the last clock edge.
  task automatic check_regs();
    check("incorrect_pred", incorrect_pred, m_ip);
    if (m_ip) check("redirect_pc", redirect_pc, m_redir);
    check("resolve_err", resolve_err, m_err);
    check("branch_cnt", branch_cnt, stat_exp(m_br));
    check("mispred_cnt", mispred_cnt, stat_exp(m_mis));
  endtask

  // One clock cycle: check registered state, apply inputs, check the
  // combinational outputs, then advance the model across the coming edge.
  task automatic drive(input bit fv, input logic [31:0] pc, input logic [31:0] tgt,
                       input bit rv, input bit rt);
    int     idx;
    bit     p;
    bit     pop;
    bit     stall;
    bit     mis;
    m_ent_t e;
    @(negedge clk);
    check_regs();
    rst           = 1'b0;
    fetch_valid   = fv;
    fetch_pc      = pc;
    fetch_target  = tgt;
    resolve_valid = rv;
    resolve_taken = rt;
    #1;
    idx   = int'(pc >> 2) % NIDX;
    p     = (m_ctr[idx] >= 2);
    pop   = rv && (mq.size() > 0) && (m_hold == 0);
    stall = (mq.size() == DEPTH) && !pop;
    check("pred_taken", pred_taken, p);
    check("pred_pc", pred_pc, p ? tgt : pc + 32'd4);
    check("fetch_stall", fetch_stall, stall);
    mis = 0;
    if (pop) begin
      e = mq.pop_front();
      mis = (rt != e.pred);
      if (rt) m_ctr[e.idx] = (m_ctr[e.idx] < 3) ? m_ctr[e.idx] + 1 : 3;
      else    m_ctr[e.idx] = (m_ctr[e.idx] > 0) ? m_ctr[e.idx] - 1 : 0;
      m_br++;
      if (mis) begin
        m_mis++;
        m_redir = rt ? e.tgt : e.fall;
      end
    end else if (rv && (mq.size() == 0) && (m_hold == 0)) begin
      m_err = 1;
    end
    m_ip = mis;
    if (mis) begin
      mq.delete();
      m_hold = FLUSH;
    end else begin
      if (m_hold > 0) m_hold--;
      if (fv && !stall) mq.push_back('{idx: idx, pred: p, fall: pc + 32'd4, tgt: tgt});
    end
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Assert reset for exactly one edge, optionally with competing traffic.
  task automatic reset_with(input bit rv, input bit rt, input bit fv);
    @(negedge clk);
    check_regs();
    rst           = 1'b1;
    fetch_valid   = fv;
    fetch_pc      = 32'h100;
    fetch_target  = 32'h200;
    resolve_valid = rv;
    resolve_taken = rt;
    model_reset();
  endtask

  bit          outs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] exp_br10;
  logic [31:0] exp_mis3;

  initial begin
    model_reset();
`ifdef BP_STATS_EN
    exp_br10 = 32'd10;
    exp_mis3 = 32'd3;
`else
    exp_br10 = 32'd0;
    exp_mis3 = 32'd0;
`endif

    // Reset state.
    reset_with(1'b0, 1'b0, 1'b0);
    idle();
    check("rst_incorrect_pred", incorrect_pred, 1'b0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_resolve_err", resolve_err, 1'b0);
    check("rst_fetch_stall", fetch_stall, 1'b0);

    // First fetch predicts not-taken; taken resolve mispredicts.
    drive(1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
    check("first_pred_taken", pred_taken, 1'b0);
    check("first_pred_pc", pred_pc, 32'h104);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle();
    check("first_incorrect_pred", incorrect_pred, 1'b1);
    check("first_redirect_pc", redirect_pc, 32'h200);
    idle();
    check("first_pulse_end", incorrect_pred, 1'b0);
    idle();
    idle();

    // Trained twice taken -> third fetch predicts taken.
    drive(1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    drive(1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
    check("trained_pred_taken", pred_taken, 1'b1);
    check("trained_pred_pc", pred_pc, 32'h200);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

    // Full FIFO stalls; push with same-cycle correct resolve is accepted.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h414 + 32'(4 * i), 32'h800, 1'b0, 1'b0);
    drive(1'b1, 32'h424, 32'h800, 1'b0, 1'b0);
    check("full_stall", fetch_stall, 1'b1);
    drive(1'b1, 32'h424, 32'h800, 1'b1, 1'b0);
    check("full_pop_no_stall", fetch_stall, 1'b0);
    drive(1'b1, 32'h428, 32'h800, 1'b0, 1'b0);
    check("full_again", fetch_stall, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Mispredict with three in flight; holdoff ignores four resolves.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h430 + 32'(4 * i), 32'h900, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < FLUSH; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    check("holdoff_err_quiet", resolve_err, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle();
    check("holdoff_err_set", resolve_err, 1'b1);

    // Reset during holdoff.
    reset_with(1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h600, 32'h700, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle();
    check("pre_rst_incorrect_pred", incorrect_pred, 1'b1);
    reset_with(1'b0, 1'b0, 1'b0);
    idle();
    check("rst_hold_incorrect_pred", incorrect_pred, 1'b0);
    check("rst_hold_redirect_pc", redirect_pc, 32'h0);
    check("rst_hold_err", resolve_err, 1'b0);
    for (int i = 0; i < NIDX; i++) begin
      drive(1'b0, 32'h2000 + 32'(4 * i), 32'h3000, 1'b0, 1'b0);
      check("rst_bht_pred", pred_taken, 1'b0);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();
    check("rst_hold_zero", resolve_err, 1'b1);
    // Weakly not-taken after reset: one taken resolve flips the prediction.
    reset_with(1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h600, 32'h700, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < FLUSH; i++) idle();
    drive(1'b0, 32'h600, 32'h700, 1'b0, 1'b0);
    check("rst_bht_weak", pred_taken, 1'b1);

    // Reset wins over a same-cycle mispredict.
    reset_with(1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h600, 32'h700, 1'b0, 1'b0);
    reset_with(1'b1, 1'b1, 1'b1);
    idle();
    check("rst_vs_mispredict", incorrect_pred, 1'b0);
    check("rst_vs_mispredict_err", resolve_err, 1'b0);

    // Statistics: 10 resolves with 3 mispredicts.
    reset_with(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h300, 32'h340, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, outs[k]);
      for (int j = 0; j <= FLUSH; j++) idle();
    end
    check("stats_branch_cnt", branch_cnt, exp_br10);
    check("stats_mispred_cnt", mispred_cnt, exp_mis3);

    // Randomized traffic with colliding indices and occasional resets.
    reset_with(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) begin
        reset_with($urandom_range(1), $urandom_range(1), $urandom_range(1));
      end else begin
        drive($urandom_range(99) < 70, $urandom() & 32'hFFFF_FFFC, $urandom(),
              $urandom_range(99) < 50, $urandom_range(1));
      end
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_pred_ctrl.md
BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

Interface
REQ-001 SHALL have parameter BHT_BITS, default 4, log2 of branch history table entries.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, in-flight unresolved branch capacity (power of 2).
REQ-003 SHALL have parameter FLUSH_CYCLES, default 4, resolve holdoff cycles after a mispredict.
REQ-004 SHALL have port clk  in  1  single clock, all state on posedge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port fetch_valid  in  1  fetch stage presents a branch this cycle.
REQ-007 SHALL have port fetch_pc  in  32  branch instruction address.
REQ-008 SHALL have port fetch_target  in  32  decoded taken target.
REQ-009 SHALL have port fetch_stall  out  1  in-flight FIFO full, fetch holds.
REQ-010 SHALL have port pred_taken  out  1  combinational prediction for fetch_pc.
REQ-011 SHALL have port pred_pc  out  32  next PC: fetch_target if pred_taken else fetch_pc+4.
REQ-012 SHALL have port resolve_valid  in  1  execute resolves oldest in-flight branch.
REQ-013 SHALL have port resolve_taken  in  1  actual outcome.
REQ-014 SHALL have port incorrect_pred  out  1  one-cycle mispredict pulse to pipeline flush control.
REQ-015 SHALL have port redirect_pc  out  32  corrected PC, valid while incorrect_pred high.
REQ-016 SHALL have port resolve_err  out  1  sticky: resolve arrived with FIFO empty.
REQ-017 SHALL have ports branch_cnt, mispred_cnt  out  16 each  statistics (see Configuration).

Function
REQ-018 SHALL index BHT with fetch_pc[BHT_BITS+1:2]; entries are 2-bit saturating counters, pred_taken = counter[1].
REQ-019 SHALL push {index, pred_taken, fetch_pc+4, fetch_target} on posedge when fetch_valid && !fetch_stall.
REQ-020 SHALL assert fetch_stall combinationally when FIFO holds FIFO_DEPTH entries and no pop occurs this cycle.
REQ-021 SHALL pop the head when resolve_valid, FIFO non-empty, and holdoff counter zero.
REQ-022 SHALL update popped entry's BHT counter: +1 saturating at 3 if taken, -1 saturating at 0 if not.
REQ-023 SHALL, on pop with resolve_taken != stored prediction, drive incorrect_pred=1 next cycle for exactly one cycle, redirect_pc = taken ? target : fallthrough.
REQ-024 SHALL, on mispredict, clear the FIFO (all younger entries squashed) and drop any same-cycle push.
REQ-025 SHALL, on mispredict, load holdoff counter with FLUSH_CYCLES; decrement per cycle to 0; resolve_valid ignored (no pop, no update) while non-zero.
REQ-026 SHALL allow simultaneous push and pop on full FIFO without stall; pointer wrap modulo FIFO_DEPTH.
REQ-027 SHALL, when fetch and resolve target the same BHT index in one cycle, predict from pre-update counter value.
REQ-028 SHALL set resolve_err on resolve_valid with empty FIFO and zero holdoff; remain set until reset.
REQ-029 SHALL hold incorrect_pred stable across full cycle so negedge-sampling flush control captures it.

Reset
REQ-030 SHALL on rst: all BHT entries 2'b01, FIFO empty, holdoff 0, incorrect_pred 0, redirect_pc 0, resolve_err 0, counters 0.
REQ-031 SHALL give rst priority over all events, including mid-holdoff and same-cycle mispredict.

Configuration
REQ-032 SHALL with BP_STATS_EN defined increment branch_cnt per pop and mispred_cnt per mispredict, both saturating at 16'hFFFF.
REQ-033 SHALL without BP_STATS_EN drive branch_cnt and mispred_cnt constant 0 with no counter registers.

Verification
REQ-034 SHALL verify: after reset, fetch pc 0x100 target 0x200 -> pred_taken 0, pred_pc 0x104; resolve taken -> incorrect_pred one cycle, redirect_pc 0x200.
REQ-035 SHALL verify: same branch resolved taken twice (holdoff respected) -> third fetch pred_taken 1, pred_pc 0x200.
REQ-036 SHALL verify: 4 pushes, no resolve -> fetch_stall 1; 5th push with same-cycle correct resolve -> accepted, stall 0.
REQ-037 SHALL verify: 3 in flight, oldest mispredicts -> FIFO empty, resolves during next 4 cycles ignored, 5th-cycle resolve with empty FIFO sets resolve_err.
REQ-038 SHALL verify: rst asserted during holdoff -> next cycle holdoff 0, incorrect_pred 0, all BHT 01.
REQ-039 SHALL verify: with BP_STATS_EN, 10 resolves incl. 3 mispredicts -> branch_cnt 10, mispred_cnt 3; without, both 0.
